// File: rtl/pipe_addsub_nbits_if.sv
// Handshake and data bundle for the pipelined add/subtract unit.
// The master side drives operands and accepts results; the slave side is the unit.
interface pipe_addsub_nbits_if #(
   parameter int WIDTH = 32
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             ci;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             co;
   logic             ovf;
   logic             zero;

   modport master (
      output flush, in_valid, a, b, sub, ci, out_ready,
      input  in_ready, out_valid, s, co, ovf, zero
   );

   modport slave (
      input  flush, in_valid, a, b, sub, ci, out_ready,
      output in_ready, out_valid, s, co, ovf, zero
   );
endinterface

// File: rtl/pipe_addsub_nbits.sv
// Pipelined WIDTH-bit add/subtract: one SW-bit slice per stage with the carry registered
// between stages; upper operand slices are skewed in and lower result slices deskewed out.
module pipe_addsub_nbits #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   pipe_addsub_nbits_if.slave bus
);

   localparam int SW = WIDTH / STAGES;

   logic adv_s;

   // A held output beat freezes every stage, so bubbles and beats keep their spacing.
   assign adv_s        = ~bus.out_valid | bus.out_ready;
   assign bus.in_ready = adv_s;

   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int RW = (k + 1) * SW;

      logic          vin_s;
      logic          cin_s;
      logic [SW-1:0] a_sl_s;
      logic [SW-1:0] b_sl_s;
      logic [SW:0]   sum_s;
      logic [RW-1:0] res_new_s;
      logic          vld_d;
      logic          vld_q;
      logic          c_d;
      logic          c_q;
      logic [RW-1:0] res_d;
      logic [RW-1:0] res_q;

      if (k == 0) begin : src
         // B is inverted on entry for subtract, so every stage is a plain adder.
         always_comb begin
            vin_s  = bus.in_valid;
            cin_s  = bus.sub ? 1'b1 : bus.ci;
            a_sl_s = bus.a[SW-1:0];
            b_sl_s = bus.sub ? ~bus.b[SW-1:0] : bus.b[SW-1:0];
         end
         assign res_new_s = sum_s[SW-1:0];
      end else begin : src
         always_comb begin
            vin_s  = stg[k-1].vld_q;
            cin_s  = stg[k-1].c_q;
            a_sl_s = stg[k-1].opr.a_q[SW-1:0];
            b_sl_s = stg[k-1].opr.b_q[SW-1:0];
         end
         assign res_new_s = {sum_s[SW-1:0], stg[k-1].res_q};
      end

      assign sum_s = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{SW{1'b0}}, cin_s};

      always_comb begin
         vld_d = vld_q;
         c_d   = c_q;
         res_d = res_q;
         if (bus.flush) begin
            vld_d = 1'b0;
         end else if (adv_s) begin
            vld_d = vin_s;
         end else begin
            vld_d = vld_q;
         end
         if (adv_s) begin
            c_d   = sum_s[SW];
            res_d = res_new_s;
         end else begin
            c_d   = c_q;
            res_d = res_q;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            c_q   <= 1'b0;
            res_q <= {RW{1'b0}};
         end else begin
            vld_q <= vld_d;
            c_q   <= c_d;
            res_q <= res_d;
         end
      end

      if (k < STAGES - 1) begin : opr
         // Only the slices not yet consumed travel on, shifted down to bit 0.
         localparam int OW = WIDTH - RW;

         logic [OW-1:0] a_new_s;
         logic [OW-1:0] b_new_s;
         logic [OW-1:0] a_d;
         logic [OW-1:0] a_q;
         logic [OW-1:0] b_d;
         logic [OW-1:0] b_q;

         if (k == 0) begin : tap
            assign a_new_s = bus.a[WIDTH-1:SW];
            assign b_new_s = bus.sub ? ~bus.b[WIDTH-1:SW] : bus.b[WIDTH-1:SW];
         end else begin : tap
            assign a_new_s = stg[k-1].opr.a_q[OW+SW-1:SW];
            assign b_new_s = stg[k-1].opr.b_q[OW+SW-1:SW];
         end

         always_comb begin
            a_d = a_q;
            b_d = b_q;
            if (adv_s) begin
               a_d = a_new_s;
               b_d = b_new_s;
            end else begin
               a_d = a_q;
               b_d = b_q;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= {OW{1'b0}};
               b_q <= {OW{1'b0}};
            end else begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end

      if (k == STAGES - 1) begin : fin
         logic msb_cin_s;
         logic ovf_d;
         logic ovf_q;
         logic zero_d;
         logic zero_q;

         assign msb_cin_s = a_sl_s[SW-1] ^ b_sl_s[SW-1] ^ sum_s[SW-1];

         always_comb begin
            ovf_d  = ovf_q;
            zero_d = zero_q;
            if (adv_s) begin
               ovf_d  = msb_cin_s ^ sum_s[SW];
               zero_d = (res_new_s == {RW{1'b0}});
            end else begin
               ovf_d  = ovf_q;
               zero_d = zero_q;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else begin
               ovf_q  <= ovf_d;
               zero_q <= zero_d;
            end
         end
      end
   end

   assign bus.out_valid = stg[STAGES-1].vld_q;
   assign bus.s         = stg[STAGES-1].res_q;
   assign bus.co        = stg[STAGES-1].c_q;
   assign bus.ovf       = stg[STAGES-1].fin.ovf_q;
   assign bus.zero      = stg[STAGES-1].fin.zero_q;

endmodule

// File: tb/tb_pipe_addsub_nbits.sv
// Scoreboard bench: two configurations (32/4 and 16/2) share one stimulus stream;
// a negedge monitor pushes model results on acceptance and pops/compares on emission.
module tb_pipe_addsub_nbits;
   localparam int W0 = 32;
   localparam int S0 = 4;
   localparam int W1 = 16;
   localparam int S1 = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic flush, in_valid, sub, ci, out_ready;
   logic [31:0] a, b;
   int rdy_mode;
   int n_vec = 0;
   int n_err = 0;

   pipe_addsub_nbits_if #(.WIDTH(W0)) if0 ();
   pipe_addsub_nbits_if #(.WIDTH(W1)) if1 ();

   pipe_addsub_nbits #(.WIDTH(W0), .STAGES(S0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   pipe_addsub_nbits #(.WIDTH(W1), .STAGES(S1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   always #5 clk = ~clk;

   assign if0.flush = flush;     assign if1.flush = flush;
   assign if0.in_valid = in_valid; assign if1.in_valid = in_valid;
   assign if0.sub = sub;         assign if1.sub = sub;
   assign if0.ci = ci;           assign if1.ci = ci;
   assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;
   assign if0.a = a;             assign if1.a = a[15:0];
   assign if0.b = b;             assign if1.b = b[15:0];

   logic [1:0] ov, ir, oc, oo, oz;
   logic [1:0][31:0] os;
   assign ov = {if1.out_valid, if0.out_valid};
   assign ir = {if1.in_ready, if0.in_ready};
   assign oc = {if1.co, if0.co};
   assign oo = {if1.ovf, if0.ovf};
   assign oz = {if1.zero, if0.zero};
   assign os[0] = if0.s;
   assign os[1] = {16'h0000, if1.s};

   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        ovf;
      logic        zero;
      longint      acc;
      longint      stl;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   function automatic void sb_push(input int d, input exp_t e);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
   endfunction
   function automatic int sb_size(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction
   function automatic exp_t sb_pop(input int d);
      if (d == 0) return q0.pop_front(); else return q1.pop_front();
   endfunction
   function automatic void sb_clear(input int d);
      if (d == 0) q0.delete(); else q1.delete();
   endfunction

   // Reference: modular arithmetic, carry from the bit above the MSB, signed
   // overflow from the operand/result sign rule.
   function automatic exp_t model(input logic [31:0] aa, input logic [31:0] bb,
                                  input logic ss, input logic cc, input int w);
      exp_t e;
      longint unsigned m, ua, ub, tot;
      m   = (64'd1 << w) - 64'd1;
      ua  = {32'h0, aa} & m;
      ub  = {32'h0, (ss ? ~bb : bb)} & m;
      tot = ua + ub + (ss ? 64'd1 : {63'd0, cc});
      e.s    = 32'(tot & m);
      e.co   = ((tot >> w) & 64'd1) != 64'd0;
      e.zero = (e.s == 32'h0);
      e.ovf  = (ua[w-1] == ub[w-1]) && (tot[w-1] != ua[w-1]);
      e.acc  = 0;
      e.stl  = 0;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, want);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 9))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'h0000_8000;
         5: return 32'h0000_7FFF;
         6: return 32'h0000_FFFF;
         default: return $urandom();
      endcase
   endfunction

   // Monitor: every negedge, compare emitted beats, check hold and in_ready, record accepts.
   longint cyc = 0;
   longint stl [2] = '{0, 0};
   logic   prv_stall [2] = '{1'b0, 1'b0};
   logic [34:0] prv_out [2];
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         for (int d = 0; d < 2; d++) begin
            exp_t e;
            int   st;
            st = (d == 0) ? S0 : S1;
            if (!rst_n) begin
               sb_clear(d);
               prv_stall[d] = 1'b0;
            end else begin
               chk($sformatf("dut%0d in_ready", d), 64'(ir[d]), 64'(!ov[d] || out_ready));
               if (prv_stall[d]) begin
                  chk($sformatf("dut%0d hold_valid", d), 64'(ov[d]), 64'd1);
                  chk($sformatf("dut%0d hold_data", d), 64'({os[d], oc[d], oo[d], oz[d]}), 64'(prv_out[d]));
               end
               if (ov[d] && sb_size(d) == 0) begin
                  chk($sformatf("dut%0d spurious_beat", d), 64'(ov[d]), 64'd0);
               end else if (ov[d] && out_ready) begin
                  e = sb_pop(d);
                  chk($sformatf("dut%0d s", d), 64'(os[d]), 64'(e.s));
                  chk($sformatf("dut%0d co", d), 64'(oc[d]), 64'(e.co));
                  chk($sformatf("dut%0d ovf", d), 64'(oo[d]), 64'(e.ovf));
                  chk($sformatf("dut%0d zero", d), 64'(oz[d]), 64'(e.zero));
                  chk($sformatf("dut%0d latency", d), 64'(cyc - e.acc), 64'(longint'(st) + stl[d] - e.stl));
               end
               prv_stall[d] = ov[d] && !out_ready && !flush;
               prv_out[d]   = {os[d], oc[d], oo[d], oz[d]};
               if (prv_stall[d]) stl[d]++;
               if (flush) begin
                  sb_clear(d);
               end else if (in_valid && ir[d]) begin
                  e     = model(a, b, sub, ci, (d == 0) ? W0 : W1);
                  e.acc = cyc;
                  e.stl = stl[d];
                  sb_push(d, e);
               end
            end
         end
      end
   end

   // Downstream readiness: 0 = always ready, 1 = random, 2 = stalled.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input logic [31:0] aa, input logic [31:0] bb, input logic ss, input logic cc);
      int   t;
      logic done;
      a = aa; b = bb; sub = ss; ci = cc; in_valid = 1'b1;
      t = 0; done = 1'b0;
      while (!done && t < 200) begin
         @(negedge clk);
         t++;
         done = if0.in_ready;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL send_timeout: got no in_ready in %0d cycles, expected acceptance", t);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, " out_valid0"}, 64'(if0.out_valid), 64'd0);
      chk({tag, " s0"}, 64'(if0.s), 64'd0);
      chk({tag, " flags0"}, 64'({if0.co, if0.ovf, if0.zero}), 64'd0);
      chk({tag, " out_valid1"}, 64'(if1.out_valid), 64'd0);
      chk({tag, " s1"}, 64'(if1.s), 64'd0);
      chk({tag, " flags1"}, 64'({if1.co, if1.ovf, if1.zero}), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; a = 32'h0; b = 32'h0;
      sub = 1'b0; ci = 1'b0; out_ready = 1'b1; rdy_mode = 0;
      #3;
      chk_zero_outputs("reset");
      repeat (2) @(posedge clk);
      #3; rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset in_ready0", 64'(if0.in_ready), 64'd1);
      chk("post_reset in_ready1", 64'(if1.in_ready), 64'd1);

      // Directed corners: slice-crossing carry, wrap to zero, subtract overflow/borrow.
      send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      send(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
      send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
      send(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0);
      send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      send(32'h0000_8000, 32'h0000_0001, 1'b1, 1'b0);
      send(32'h0000_7FFF, 32'h0000_0000, 1'b0, 1'b1);
      idle(8);

      // Eight back-to-back beats with downstream stalled in cycles 6-8.
      fork
         begin
            for (int i = 0; i < 8; i++)
               send($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         begin
            repeat (5) @(posedge clk);
            #1; rdy_mode = 2;
            repeat (3) @(posedge clk);
            #1; rdy_mode = 0;
         end
      join
      idle(8);

      // Flush with three beats in flight; the beat offered alongside is dropped.
      for (int i = 0; i < 3; i++)
         send(pick(), pick(), 1'b0, 1'($urandom_range(0, 1)));
      a = $urandom(); b = $urandom(); flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("flush_quiet0", 64'(if0.out_valid), 64'd0);
         chk("flush_quiet1", 64'(if1.out_valid), 64'd0);
      end
      @(posedge clk); #1;
      send(32'h1234_5678, 32'h0000_0001, 1'b1, 1'b0);
      idle(8);

      // Asynchronous reset mid-stream, asserted and released away from the clock edge.
      for (int i = 0; i < 5; i++)
         send(pick() | 32'h0001_0001, pick(), 1'b0, 1'b1);
      #2; rst_n = 1'b0;
      #1; chk_zero_outputs("async_reset");
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3; rst_n = 1'b1;
      chk("release in_ready0", 64'(if0.in_ready), 64'd1);
      chk("release in_ready1", 64'(if1.in_ready), 64'd1);
      idle(8);

      // Randomised traffic with random backpressure, gaps and occasional flushes.
      rdy_mode = 1;
      for (int i = 0; i < 300; i++) begin
         send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         if ($urandom_range(0, 49) == 0) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
         end
      end

      rdy_mode = 0;
      idle(1);
      begin
         int t;
         t = 0;
         while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
            @(posedge clk); t++;
         end
      end
      #1;
      chk("drain0", 64'(q0.size()), 64'd0);
      chk("drain1", 64'(q1.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
